// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM states, blanking
// constants and the active-low hex segment table ({g,f,e,d,c,b,a}).
package sevenseg_pkg;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_e;

  localparam int unsigned MAX_DIGITS = 32;

  localparam logic [6:0]            SEG_OFF    = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF = {MAX_DIGITS{1'b1}};

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble to active-low 7-segment decode.
module hex_to_sevenseg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_seg(nib_i);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with anti-ghosting
// blanking and per-frame value latching. Optional: SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  clk_div,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned GC_W  = $clog2(GUARD_CYCLES + 1);

  localparam logic [IDX_W-1:0]    IDX_FIRST  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [GC_W-1:0]     GC_ZERO    = {GC_W{1'b0}};
  localparam logic [GC_W-1:0]     GC_LAST    = GC_W'(GUARD_CYCLES - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF     = ANODES_OFF[N_DIGITS-1:0];
  localparam logic [N_DIGITS-1:0] AN_ONEHOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

  scan_state_e           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [GC_W-1:0]       guard_cnt_q;
  logic                  clk_div_q;
  logic [4*N_DIGITS-1:0] shadow_val_q;
  logic [N_DIGITS-1:0]   shadow_en_q;
  logic [N_DIGITS-1:0]   shadow_dp_q;
  logic [N_DIGITS-1:0]   anodes_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  logic                  tick_s;
  logic                  load_s;
  logic                  show_en_s;
  logic                  show_dp_s;
  logic [4*N_DIGITS-1:0] nib_src_s;
  logic [3:0]            show_nib_s;
  logic [6:0]            show_seg_s;
  logic [N_DIGITS-1:0]   load_en_s;
  logic [IDX_W-1:0]      idx_d;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // Keep digit i only if some nibble at or above i is nonzero; digit 0 always kept.
  function automatic logic [N_DIGITS-1:0] lead_keep(input logic [4*N_DIGITS-1:0] v);
    logic seen;
    seen = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'h0) seen = 1'b1;
      else                     seen = seen;
      lead_keep[i] = seen | (i == 0);
    end
  endfunction

  assign load_en_s = digit_en & lead_keep(value);
`else
  assign load_en_s = digit_en;
`endif

  assign tick_s = clk_div & ~clk_div_q;
  assign load_s = (idx_q == IDX_FIRST);

  // Digit about to be shown: live inputs when this switch starts a new frame, shadow otherwise
  always_comb begin
    nib_src_s = shadow_val_q;
    show_en_s = shadow_en_q[idx_q];
    show_dp_s = shadow_dp_q[idx_q];
    idx_d     = idx_q;
    if (load_s) begin
      nib_src_s = value;
      show_en_s = load_en_s[idx_q];
      show_dp_s = dp_mask[idx_q];
    end else begin
      nib_src_s = shadow_val_q;
      show_en_s = shadow_en_q[idx_q];
      show_dp_s = shadow_dp_q[idx_q];
    end
    if (idx_q == IDX_LAST) idx_d = IDX_FIRST;
    else                   idx_d = idx_q + 1'b1;
  end

  assign show_nib_s = nib_src_s[{idx_q, 2'b00} +: 4];

  hex_to_sevenseg u_decode (
    .nib_i (show_nib_s),
    .seg_o (show_seg_s)
  );

  // Scan FSM, frame shadow registers and outputs registered from the next state
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_BLANK;
      idx_q        <= IDX_FIRST;
      guard_cnt_q  <= GC_ZERO;
      clk_div_q    <= 1'b0;
      shadow_val_q <= {(4*N_DIGITS){1'b0}};
      shadow_en_q  <= {N_DIGITS{1'b0}};
      shadow_dp_q  <= {N_DIGITS{1'b0}};
      anodes_q     <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      clk_div_q <= clk_div;
      case (state_q)
        S_BLANK: begin
          // Ticks arriving here are intentionally dropped, not queued
          if (guard_cnt_q == GC_LAST) begin
            state_q     <= S_SHOW;
            guard_cnt_q <= GC_ZERO;
            if (load_s) begin
              shadow_val_q <= value;
              shadow_en_q  <= load_en_s;
              shadow_dp_q  <= dp_mask;
            end
            if (show_en_s) begin
              anodes_q <= ~(AN_ONEHOT0 << idx_q);
              seg_q    <= show_seg_s;
              dp_q     <= ~show_dp_s;
            end else begin
              anodes_q <= AN_OFF;
              seg_q    <= SEG_OFF;
              dp_q     <= 1'b1;
            end
          end else begin
            guard_cnt_q <= guard_cnt_q + 1'b1;
            anodes_q    <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
          end
        end
        S_SHOW: begin
          if (tick_s) begin
            state_q  <= S_BLANK;
            idx_q    <= idx_d;
            anodes_q <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
          end else begin
            state_q <= S_SHOW;
          end
        end
        default: begin
          state_q     <= S_BLANK;
          guard_cnt_q <= GC_ZERO;
          anodes_q    <= AN_OFF;
          seg_q       <= SEG_OFF;
          dp_q        <= 1'b1;
        end
      endcase
    end
  end

  assign anodes = anodes_q;
  assign seg    = seg_q;
  assign dp     = dp_q;

endmodule
